fft_ctrl: RTL

FFT_CTRL -- requirements
Module: fft_ctrl

---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_idx_gen.sv | 41 ++++
 rtl/fft_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT controller defaults and FSM state encoding
package fft_pkg;

    // Default geometry: 256-point FFT, 8-bit indices, 3-cycle butterfly pipe
    localparam int FFT_LOG2N    = 8;
    localparam int FFT_ADDRSIZE = 8;
    localparam int FFT_PIPE_LAT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_t;

endpackage

// File: rtl/fft_idx_gen.sv
// rtl/fft_idx_gen.sv - radix-2 butterfly data/twiddle index generator
//
// Purely combinational.
//   j        : butterfly counter within the stage (0..N/2-1)
//   s        : stage number (0..LOG2N-1)
//   addr_a   : upper butterfly data index
//   addr_b   : lower butterfly data index (addr_a + 2^s)
//   rom_addr : twiddle index k (0..N/2-1)
module fft_idx_gen
    import fft_pkg::*;
#(
    parameter int LOG2N    = FFT_LOG2N,
    parameter int ADDRSIZE = FFT_ADDRSIZE
) (
    input  logic [ADDRSIZE-1:0] j,
    input  logic [2:0]          s,
    output logic [ADDRSIZE-1:0] addr_a,
    output logic [ADDRSIZE-1:0] addr_b,
    output logic [ADDRSIZE-1:0] rom_addr
);

    localparam logic [ADDRSIZE-1:0] ONE   = ADDRSIZE'(1);
    localparam logic [3:0]          S_TOP = 4'(LOG2N - 1);

    // Shift amounts are widened to 4 bits so that s+1 does not wrap at s=7
    logic [3:0]          s_w;
    logic [ADDRSIZE-1:0] half;
    logic [ADDRSIZE-1:0] pos;

    assign s_w = {1'b0, s};

    always_comb begin
        half     = ONE << s_w;
        pos      = j & (half - ONE);
        // Insert a zero at bit s: group index moves up one place, pos stays
        addr_a   = ((j >> s_w) << (s_w + 4'd1)) | pos;
        addr_b   = addr_a + half;
        rom_addr = pos << (S_TOP - s_w);
    end

endmodule

// File: rtl/fft_ctrl.sv
// rtl/fft_ctrl.sv - in-place radix-2 FFT address sequencer and stage FSM
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : run one full FFT (honoured only in IDLE)
//   stall             : datapath cannot take a butterfly this cycle
//   busy              : FSM in RUN or DRAIN
//   done              : one-cycle completion pulse
//   stage             : current stage s
//   bfly_valid        : addr_a/addr_b/rom_addr valid this cycle
//   addr_a, addr_b    : butterfly data indices
//   rom_cs, rom_addr  : twiddle ROM select and index
//   tw_valid          : bfly_valid delayed to line up with ROM data
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N    = FFT_LOG2N,
    parameter int ADDRSIZE = FFT_ADDRSIZE,
    parameter int PIPE_LAT = FFT_PIPE_LAT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stall,
    output logic                busy,
    output logic                done,
    output logic [2:0]          stage,
    output logic                bfly_valid,
    output logic [ADDRSIZE-1:0] addr_a,
    output logic [ADDRSIZE-1:0] addr_b,
    output logic                rom_cs,
    output logic [ADDRSIZE-1:0] rom_addr,
    output logic                tw_valid
);

    localparam int                  DW         = (PIPE_LAT > 2) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DW-1:0]       DRAIN_LAST = DW'(PIPE_LAT - 1);
    localparam logic [DW-1:0]       DONE1      = DW'(1);
    localparam logic [ADDRSIZE-1:0] J_LAST     = ADDRSIZE'((1 << (LOG2N - 1)) - 1);
    localparam logic [ADDRSIZE-1:0] J_ONE      = ADDRSIZE'(1);
    localparam logic [2:0]          STAGE_LAST = 3'(LOG2N - 1);

    fft_state_t          state;
    fft_state_t          state_nxt;
    logic [ADDRSIZE-1:0] j;
    logic [2:0]          stage_q;
    logic [DW-1:0]       dcnt;
    logic                valid;
    logic                drain_end;
    logic                last_stage;

    logic [ADDRSIZE-1:0] gen_a;
    logic [ADDRSIZE-1:0] gen_b;
    logic [ADDRSIZE-1:0] gen_r;
    logic [ADDRSIZE-1:0] hold_a;
    logic [ADDRSIZE-1:0] hold_b;
    logic [ADDRSIZE-1:0] hold_r;

    fft_idx_gen #(
        .LOG2N    (LOG2N),
        .ADDRSIZE (ADDRSIZE)
    ) u_idx_gen (
        .j        (j),
        .s        (stage_q),
        .addr_a   (gen_a),
        .addr_b   (gen_b),
        .rom_addr (gen_r)
    );

    assign drain_end  = (state == ST_DRAIN) && (dcnt == DRAIN_LAST);
    assign last_stage = (stage_q == STAGE_LAST);

    always_comb begin
        state_nxt = state;
        valid     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    valid = 1'b1;
                    if (j == J_LAST) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Drain length ignores stall: it only covers pipe latency
                if (drain_end) begin
                    state_nxt = last_stage ? ST_DONE : ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            j        <= '0;
            stage_q  <= '0;
            dcnt     <= '0;
            tw_valid <= 1'b0;
            hold_a   <= '0;
            hold_b   <= '0;
            hold_r   <= '0;
        end else begin
            state    <= state_nxt;
            tw_valid <= valid;

            if (valid) begin
                j      <= (j == J_LAST) ? '0 : j + J_ONE;
                hold_a <= gen_a;
                hold_b <= gen_b;
                hold_r <= gen_r;
            end

            if (state == ST_DRAIN) begin
                dcnt <= drain_end ? '0 : dcnt + DONE1;
            end else begin
                dcnt <= '0;
            end

            if (drain_end && !last_stage) begin
                stage_q <= stage_q + 3'd1;
            end else if (state == ST_DONE) begin
                stage_q <= '0;
            end
        end
    end

    // Addresses track the generator on valid cycles and freeze otherwise
    assign addr_a     = valid ? gen_a : hold_a;
    assign addr_b     = valid ? gen_b : hold_b;
    assign rom_addr   = valid ? gen_r : hold_r;
    assign bfly_valid = valid;
    assign rom_cs     = valid;
    assign busy       = (state == ST_RUN) || (state == ST_DRAIN);
    assign done       = (state == ST_DONE);
    assign stage      = stage_q;

endmodule
